alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 24 ++
 rtl/alu_pipe.sv | 122 ++++++++++++
 tb/tb_alu_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response handshake and operand/result bus of the pipelined ALU
interface alu_pipe_if #(parameter int WIDTH = 64);
  logic             inValid;
  logic             inReady;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] readDataRegister1;
  logic [WIDTH-1:0] inputSaidaMuxALUSrc;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] ALUResult;
  logic             zeroFlag;
  logic             carryFlag;
  logic             negativeFlag;
  logic             overflowFlag;
  logic             illegalOp;
  modport master (
    output inValid, ALUControl, readDataRegister1, inputSaidaMuxALUSrc, outReady,
    input  inReady, outValid, ALUResult, zeroFlag, carryFlag, negativeFlag, overflowFlag, illegalOp
  );
  modport slave (
    input  inValid, ALUControl, readDataRegister1, inputSaidaMuxALUSrc, outReady,
    output inReady, outValid, ALUResult, zeroFlag, carryFlag, negativeFlag, overflowFlag, illegalOp
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with one-cycle logic/arith ops and bit-serial shifts
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h6,
                         OP_EOR = 4'h7, OP_SLL = 4'h8, OP_SRL = 4'h9, OP_SRA = 4'hA;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d, r, step, a, b;
  logic [SHW-1:0]   cnt_q, cnt_d, s;
  logic [3:0]       op, op_q, op_d;
  logic [WIDTH:0]   add, sub;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, ill_q, ill_d;
  logic             is_sh, legal, c, v;
  assign a  = bus.readDataRegister1;
  assign b  = bus.inputSaidaMuxALUSrc;
  assign op = bus.ALUControl;
  assign s  = b[SHW-1:0];
  // Single-cycle datapath for the incoming request plus one step of the in-flight shift
  always_comb begin
    add   = {1'b0, a} + {1'b0, b};
    sub   = {1'b0, a} - {1'b0, b};
    is_sh = op inside {OP_SLL, OP_SRL, OP_SRA};
    legal = is_sh || op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_EOR};
    r     = op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_ADD ? add[WIDTH-1:0] :
            op == OP_SUB ? sub[WIDTH-1:0] :
            op == OP_EOR ? a ^ b :
            is_sh        ? a : '0;
    c     = op == OP_ADD ? add[WIDTH] : op == OP_SUB ? sub[WIDTH] : 1'b0;
    v     = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]) :
            op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    step  = op_q == OP_SLL ? sh_q << 1 :
            op_q == OP_SRL ? sh_q >> 1 : {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
  end
  // Next-state: accept in IDLE, shift one bit per BUSY cycle, hold in DONE until consumed
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (bus.inValid) begin
        op_d = op;
        if (is_sh && s != '0) begin
          state_d = BUSY;
          sh_d    = a;
          cnt_d   = s;
        end else begin
          state_d = DONE;
          res_d   = r;
          z_d     = r == '0;
          c_d     = c;
          n_d     = r[WIDTH-1];
          v_d     = v;
          ill_d   = !legal;
        end
      end
      BUSY: begin
        sh_d  = step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
          res_d   = step;
          z_d     = step == '0;
          c_d     = 1'b0;
          n_d     = step[WIDTH-1];
          v_d     = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DONE: state_d = bus.outReady ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State and result registers; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      ill_q   <= ill_d;
    end
  end
  assign bus.inReady      = state_q == IDLE && !reset;
  assign bus.outValid     = state_q == DONE;
  assign bus.ALUResult    = res_q;
  assign bus.zeroFlag     = z_q;
  assign bus.carryFlag    = c_q;
  assign bus.negativeFlag = n_q;
  assign bus.overflowFlag = v_q;
  assign bus.illegalOp    = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for 64-bit and 8-bit alu_pipe instances
module tb_alu_pipe;
  typedef struct packed {
    logic [127:0] r;
    logic z, c, n, v, ill;
    int unsigned lat;
  } exp_t;
  localparam logic [3:0] AND_ = 4'h0, OR_ = 4'h1, ADD = 4'h2, SUB = 4'h6,
                         EOR = 4'h7, SLL = 4'h8, SRL = 4'h9, SRA = 4'hA;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  alu_pipe_if #(.WIDTH(64)) i64();
  alu_pipe_if #(.WIDTH(8))  i8();
  alu_pipe #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(i64));
  alu_pipe #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(i8));
  always #5 clk = ~clk;

  function automatic exp_t model(input int w, input logic [3:0] op, input logic [127:0] a0, input logic [127:0] b0);
    exp_t e;
    logic [127:0] m, a, b, sa, sbx, r, t;
    int s;
    e = '0;
    m = (128'd1 << w) - 128'd1;
    a = a0 & m;
    b = b0 & m;
    s = int'(b[6:0]) & (w - 1);
    sa = a[w-1] ? (a | ~m) : a;
    sbx = b[w-1] ? (b | ~m) : b;
    r = '0;
    case (op)
      AND_: r = a & b;
      OR_:  r = a | b;
      EOR:  r = a ^ b;
      ADD: begin t = a + b; r = t & m; e.c = t[w]; t = sa + sbx; e.v = t[w] != t[w-1]; end
      SUB: begin r = (a - b) & m; e.c = a < b; t = sa - sbx; e.v = t[w] != t[w-1]; end
      SLL: r = (a << s) & m;
      SRL: r = a >> s;
      SRA: begin t = $signed(sa) >>> s; r = t & m; end
      default: e.ill = 1'b1;
    endcase
    if (op inside {SLL, SRL, SRA}) e.lat = s;
    e.r = r;
    e.z = r == '0;
    e.n = r[w-1];
    return e;
  endfunction

  task automatic issue(input bit w8, input logic [3:0] op, input logic [127:0] a, input logic [127:0] b);
    if (w8) begin
      i8.inValid = 1'b1; i8.ALUControl = op; i8.readDataRegister1 = a[7:0]; i8.inputSaidaMuxALUSrc = b[7:0];
    end else begin
      i64.inValid = 1'b1; i64.ALUControl = op; i64.readDataRegister1 = a[63:0]; i64.inputSaidaMuxALUSrc = b[63:0];
    end
    sb.push_back(model(w8 ? 8 : 64, op, a, b));
    @(posedge clk); #1;
    i8.inValid = 1'b0; i64.inValid = 1'b0;
    i8.readDataRegister1 = ~a[7:0]; i8.inputSaidaMuxALUSrc = ~b[7:0]; i8.ALUControl = ~op;
    i64.readDataRegister1 = ~a[63:0]; i64.inputSaidaMuxALUSrc = ~b[63:0]; i64.ALUControl = ~op;
  endtask

  task automatic collect(input bit w8, output exp_t o, output logic rdy);
    int cyc = 0;
    rdy = 1'b0;
    while (!(w8 ? i8.outValid : i64.outValid) && cyc < 200) begin
      rdy |= w8 ? i8.inReady : i64.inReady;
      @(posedge clk); #1;
      cyc++;
    end
    o = '0;
    o.r = w8 ? {120'b0, i8.ALUResult} : {64'b0, i64.ALUResult};
    o.z = w8 ? i8.zeroFlag : i64.zeroFlag;
    o.c = w8 ? i8.carryFlag : i64.carryFlag;
    o.n = w8 ? i8.negativeFlag : i64.negativeFlag;
    o.v = w8 ? i8.overflowFlag : i64.overflowFlag;
    o.ill = w8 ? i8.illegalOp : i64.illegalOp;
    o.lat = cyc;
  endtask

  task automatic ack(input bit w8, output logic ov, output logic ir);
    if (w8) i8.outReady = 1'b1; else i64.outReady = 1'b1;
    @(posedge clk); #1;
    i8.outReady = 1'b0; i64.outReady = 1'b0;
    ov = w8 ? i8.outValid : i64.outValid;
    ir = w8 ? i8.inReady : i64.inReady;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({i64.outValid, i64.inReady, i64.ALUResult, i64.zeroFlag, i64.carryFlag, i64.negativeFlag, i64.overflowFlag, i64.illegalOp,
         i8.outValid, i8.inReady, i8.ALUResult, i8.zeroFlag, i8.carryFlag, i8.negativeFlag, i8.overflowFlag, i8.illegalOp} !== '0) begin
      fails++;
      $display("FAIL reset_state res64=%h ov=%b ir=%b res8=%h ov=%b ir=%b need all zero", i64.ALUResult, i64.outValid, i64.inReady, i8.ALUResult, i8.outValid, i8.inReady);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({i64.inReady, i8.inReady} !== 2'b11) begin
      fails++;
      $display("FAIL reset_release inReady=%b%b need 11", i64.inReady, i8.inReady);
    end
  endtask

  task automatic test_arith64();
    logic [3:0]  ot [11] = '{ADD, SUB, SUB, AND_, OR_, EOR, ADD, 4'h3, SLL, SUB, ADD};
    logic [63:0] at [11] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h8000000000000000, 64'hF0F0F0F0F0F0F0F0, 64'hF0F0000000000000,
                             64'hFFFF0000FFFF0000, 64'h7FFFFFFFFFFFFFFF, 64'h1234, 64'h8000000000000001, 64'h5, 64'h8000000000000000};
    logic [63:0] bt [11] = '{64'h1, 64'h1, 64'h0800000000000000, 64'h0FF00FF00FF00FF0, 64'h000000000000000F,
                             64'hFF00FF00FF00FF00, 64'h1, 64'h5678, 64'h40, 64'h5, 64'h8000000000000000};
    exp_t o, e;
    logic rdy, ov, ir;
    logic [3:0] op;
    logic [63:0] a, b;
    for (int i = 0; i < 31; i++) begin
      op = i < 11 ? ot[i] : 4'($urandom_range(0, 15));
      a = i < 11 ? at[i] : {$urandom, $urandom};
      b = i < 11 ? bt[i] : {$urandom, $urandom};
      issue(1'b0, op, {64'b0, a}, {64'b0, b});
      collect(1'b0, o, rdy);
      e = sb.pop_front();
      tests++;
      if ({o.r, o.z, o.c, o.n, o.v, o.ill} !== {e.r, e.z, e.c, e.n, e.v, e.ill}) begin
        fails++;
        $display("FAIL arith64#%0d op=%h res=%h zcnvi=%b%b%b%b%b need res=%h zcnvi=%b%b%b%b%b", i, op, o.r[63:0], o.z, o.c, o.n, o.v, o.ill, e.r[63:0], e.z, e.c, e.n, e.v, e.ill);
      end
      tests++;
      if (o.lat !== e.lat || rdy) begin
        fails++;
        $display("FAIL arith64_lat#%0d latency=%0d ready_in_flight=%b need %0d/0", i, o.lat, rdy, e.lat);
      end
      ack(1'b0, ov, ir);
      tests++;
      if ({ov, ir} !== 2'b01) begin
        fails++;
        $display("FAIL arith64_ack#%0d outValid/inReady=%b%b need 01", i, ov, ir);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  ot [6] = '{SRA, SRL, SLL, SRA, SRL, SLL};
    logic [63:0] at [6] = '{64'h8000000000000000, 64'h8000000000000000, 64'h1, 64'h4000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'hDEADBEEFCAFEF00D};
    logic [63:0] bt [6] = '{64'd4, 64'd4, 64'd63, 64'd62, 64'h7F, 64'd1};
    exp_t o, e;
    logic rdy, ov, ir;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, ot[i], {64'b0, at[i]}, {64'b0, bt[i]});
      collect(1'b0, o, rdy);
      e = sb.pop_front();
      tests++;
      if ({o.r, o.z, o.c, o.n, o.v, o.ill} !== {e.r, e.z, e.c, e.n, e.v, e.ill}) begin
        fails++;
        $display("FAIL shift#%0d res=%h zcnvi=%b%b%b%b%b need res=%h zcnvi=%b%b%b%b%b", i, o.r[63:0], o.z, o.c, o.n, o.v, o.ill, e.r[63:0], e.z, e.c, e.n, e.v, e.ill);
      end
      tests++;
      if (o.lat !== e.lat || rdy) begin
        fails++;
        $display("FAIL shift_lat#%0d latency=%0d ready_in_flight=%b need %0d/0", i, o.lat, rdy, e.lat);
      end
      ack(1'b0, ov, ir);
      tests++;
      if ({ov, ir} !== 2'b01) begin
        fails++;
        $display("FAIL shift_ack#%0d outValid/inReady=%b%b need 01", i, ov, ir);
      end
    end
  endtask

  task automatic test_width8();
    logic [3:0] ot [4] = '{ADD, SLL, SRA, SUB};
    logic [7:0] at [4] = '{8'h7F, 8'h01, 8'h90, 8'h80};
    logic [7:0] bt [4] = '{8'h01, 8'h07, 8'h03, 8'h01};
    exp_t o, e;
    logic rdy, ov, ir;
    logic [3:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = i < 4 ? ot[i] : 4'($urandom_range(0, 15));
      a = i < 4 ? at[i] : 8'($urandom);
      b = i < 4 ? bt[i] : 8'($urandom);
      issue(1'b1, op, {120'b0, a}, {120'b0, b});
      collect(1'b1, o, rdy);
      e = sb.pop_front();
      tests++;
      if ({o.r, o.z, o.c, o.n, o.v, o.ill} !== {e.r, e.z, e.c, e.n, e.v, e.ill}) begin
        fails++;
        $display("FAIL w8#%0d op=%h res=%h zcnvi=%b%b%b%b%b need res=%h zcnvi=%b%b%b%b%b", i, op, o.r[7:0], o.z, o.c, o.n, o.v, o.ill, e.r[7:0], e.z, e.c, e.n, e.v, e.ill);
      end
      tests++;
      if (o.lat !== e.lat || rdy) begin
        fails++;
        $display("FAIL w8_lat#%0d latency=%0d ready_in_flight=%b need %0d/0", i, o.lat, rdy, e.lat);
      end
      ack(1'b1, ov, ir);
      tests++;
      if ({ov, ir} !== 2'b01) begin
        fails++;
        $display("FAIL w8_ack#%0d outValid/inReady=%b%b need 01", i, ov, ir);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    logic rdy, ov, ir, stable;
    logic [63:0] x, y;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    issue(1'b0, ADD, 128'h0123456789ABCDEF, 128'h1111111111111111);
    collect(1'b0, o, rdy);
    e = sb.pop_front();
    tests++;
    if (o.r !== e.r || o.lat !== e.lat) begin
      fails++;
      $display("FAIL bp_first res=%h lat=%0d need %h/%0d", o.r[63:0], o.lat, e.r[63:0], e.lat);
    end
    i64.inValid = 1'b1; i64.ALUControl = EOR; i64.readDataRegister1 = x; i64.inputSaidaMuxALUSrc = y;
    stable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!i64.outValid || i64.ALUResult !== e.r[63:0] || i64.inReady) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL bp_hold res=%h ov=%b ir=%b need %h/1/0", i64.ALUResult, i64.outValid, i64.inReady, e.r[63:0]);
    end
    i64.outReady = 1'b1;
    @(posedge clk); #1;
    i64.outReady = 1'b0;
    tests++;
    if ({i64.outValid, i64.inReady} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release outValid/inReady=%b%b need 01", i64.outValid, i64.inReady);
    end
    sb.push_back(model(64, EOR, {64'b0, x}, {64'b0, y}));
    @(posedge clk); #1;
    i64.inValid = 1'b0; i64.readDataRegister1 = ~x;
    collect(1'b0, o, rdy);
    e = sb.pop_front();
    tests++;
    if ({o.r, o.z, o.c, o.n, o.v, o.ill} !== {e.r, e.z, e.c, e.n, e.v, e.ill} || o.lat !== e.lat) begin
      fails++;
      $display("FAIL bp_second res=%h lat=%0d need %h/%0d", o.r[63:0], o.lat, e.r[63:0], e.lat);
    end
    ack(1'b0, ov, ir);
    tests++;
    if ({ov, ir} !== 2'b01) begin
      fails++;
      $display("FAIL bp_ack outValid/inReady=%b%b need 01", ov, ir);
    end
  endtask

  task automatic test_reset_abort();
    exp_t o, e;
    logic rdy, ov, ir, seen;
    issue(1'b0, SLL, 128'h1, 128'd40);
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({i64.outValid, i64.inReady, i64.ALUResult, i64.zeroFlag, i64.carryFlag, i64.negativeFlag, i64.overflowFlag, i64.illegalOp} !== '0) begin
      fails++;
      $display("FAIL abort_async res=%h ov=%b ir=%b need zero", i64.ALUResult, i64.outValid, i64.inReady);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (i64.inReady !== 1'b1) begin
      fails++;
      $display("FAIL abort_release inReady=%b need 1", i64.inReady);
    end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      seen |= i64.outValid;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_no_result outValid_seen=%b need 0", seen);
    end
    for (int w = 0; w < 2; w++) begin
      issue(w[0], 4'hF, 128'hA5, 128'h5A);
      collect(w[0], o, rdy);
      e = sb.pop_front();
      tests++;
      if ({o.r, o.z, o.c, o.n, o.v, o.ill, o.lat} !== {e.r, e.z, e.c, e.n, e.v, e.ill, e.lat}) begin
        fails++;
        $display("FAIL illegal_w%0d res=%h zcnvi=%b%b%b%b%b lat=%0d need res=%h zcnvi=%b%b%b%b%b lat=%0d", w, o.r[63:0], o.z, o.c, o.n, o.v, o.ill, o.lat, e.r[63:0], e.z, e.c, e.n, e.v, e.ill, e.lat);
      end
      ack(w[0], ov, ir);
    end
  endtask

  initial begin
    i64.inValid = 1'b0; i64.outReady = 1'b0; i64.ALUControl = '0; i64.readDataRegister1 = '0; i64.inputSaidaMuxALUSrc = '0;
    i8.inValid = 1'b0; i8.outReady = 1'b0; i8.ALUControl = '0; i8.readDataRegister1 = '0; i8.inputSaidaMuxALUSrc = '0;
    test_reset();
    test_arith64();
    test_shifts();
    test_width8();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
